// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, column type and InvMixColumns FSM encoding
package aes_pkg;
    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic [7:0] C_0E = 8'h0E;
    localparam logic [7:0] C_0B = 8'h0B;
    localparam logic [7:0] C_0D = 8'h0D;
    localparam logic [7:0] C_09 = 8'h09;
    typedef logic [31:0] col_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/inv_mixcolumn.sv
// inv_mixcolumn: combinational InvMixColumns of one 32-bit column (row r = bits [8r+7:8r])
module inv_mixcolumn
    import aes_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);
    logic [7:0] b1 [4];
    logic [7:0] b2 [4];
    logic [7:0] b4 [4];
    logic [7:0] b8 [4];

    // Coefficients are sums of x8/x4/x2/x1 terms, so each bit picks one chained xtime product
    function automatic logic [7:0] gmul(input logic [7:0] coef, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p4,
                                        input logic [7:0] p8);
        return (((coef & 8'h08) != 8'h00) ? p8 : 8'h00) ^
               (((coef & 8'h04) != 8'h00) ? p4 : 8'h00) ^
               (((coef & 8'h02) != 8'h00) ? p2 : 8'h00) ^
               (((coef & 8'h01) != 8'h00) ? p1 : 8'h00);
    endfunction

    genvar i;
    for (i = 0; i < 4; i++) begin : g_byte
        assign b1[i] = col_in[8*i +: 8];
        xtime u_x2 (.byte_in(b1[i]), .byte_out(b2[i]));
        xtime u_x4 (.byte_in(b2[i]), .byte_out(b4[i]));
        xtime u_x8 (.byte_in(b4[i]), .byte_out(b8[i]));
    end

    // Row r uses the matrix row {0e 0b 0d 09} rotated right by r
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            col_out[8*r +: 8] =
                gmul(C_0E, b1[2'(r)],   b2[2'(r)],   b4[2'(r)],   b8[2'(r)])   ^
                gmul(C_0B, b1[2'(r+1)], b2[2'(r+1)], b4[2'(r+1)], b8[2'(r+1)]) ^
                gmul(C_0D, b1[2'(r+2)], b2[2'(r+2)], b4[2'(r+2)], b8[2'(r+2)]) ^
                gmul(C_09, b1[2'(r+3)], b2[2'(r+3)], b4[2'(r+3)], b8[2'(r+3)]);
        end
    end
endmodule

// File: rtl/xtime.sv
// xtime: multiply a byte by 2 in GF(2^8) modulo 0x11B
module xtime
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);
    assign byte_out = {byte_in[6:0], 1'b0} ^ (byte_in[7] ? GF_POLY : 8'h00);
endmodule

// File: rtl/inv_mixcolumns_iter.sv
// inv_mixcolumns_iter: AES InvMixColumns, column-serial by default; INV_MIXCOLUMNS_UNROLL_EN gives a single-cycle four-column version
module inv_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int NB           = 4,
    parameter bit CLR_ON_START = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         done,
    output logic         busy
);
    if (NB != 4) begin : g_nb_check
        $error("inv_mixcolumns_iter: NB must be 4");
    end

    logic [127:0] state_out_q, state_out_d;
    logic         done_q, done_d;

    assign state_out = state_out_q;
    assign done      = done_q;

`ifdef INV_MIXCOLUMNS_UNROLL_EN
    logic [127:0] imc;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_col
        inv_mixcolumn u_col (.col_in(state_in[32*i +: 32]), .col_out(imc[32*i +: 32]));
    end

    assign busy = 1'b0;

    // Every accepted request completes on its own edge
    always_comb begin
        state_out_d = ena ? imc : state_out_q;
        done_d      = ena;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_out_q <= state_out_d;
            done_q      <= done_d;
        end
    end
`else
    state_t       fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic [127:0] result_q, result_d;
    logic         busy_q, busy_d;
    col_t         col_in, col_out;

    assign busy   = busy_q;
    assign col_in = work_q[{col_q, 5'd0} +: 32];

    inv_mixcolumn u_col (.col_in(col_in), .col_out(col_out));

    // Capture on start, then one column per edge; the last column bypasses result straight to state_out
    always_comb begin
        fsm_d       = fsm_q;
        col_d       = col_q;
        work_d      = work_q;
        result_d    = result_q;
        state_out_d = state_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (ena) begin
                    work_d = state_in;
                    col_d  = 2'd0;
                    busy_d = 1'b1;
                    fsm_d  = RUN;
                    if (CLR_ON_START) state_out_d = '0;
                end
            end
            RUN: begin
                result_d[{col_q, 5'd0} +: 32] = col_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_out_d = {col_out, result_q[95:0]};
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    col_d       = 2'd0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            result_q    <= '0;
            state_out_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            work_q      <= work_d;
            result_q    <= result_d;
            state_out_q <= state_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end
`endif
endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// tb_inv_mixcolumns_iter: directed and round-trip checks of the serial InvMixColumns block
module tb_inv_mixcolumns_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         done;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [127:0] FIPS_IN  = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;
    localparam logic [127:0] FIPS_OUT = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
    localparam logic [127:0] FIXED    = 128'h01010101_01010101_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] ROT_IN   = 128'hbca14d8e_f8bd7e4d_d6d7d5d5_9d58dc9f;
    localparam logic [127:0] ROT_OUT  = 128'h455313db_4c31262d_d5d4d4d4_5c220af2;

    inv_mixcolumns_iter dut (
        .clk(clk), .rst(rst), .ena(ena), .state_in(state_in),
        .state_out(state_out), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward (encryption) MixColumns, used to build round-trip stimulus
    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    task automatic run_op(input logic [127:0] s, input logic [127:0] prev,
                          input logic [127:0] exp, input string tag);
        int n;
        ena = 1'b1;
        state_in = s;
        tick();
        ena = 1'b0;
        state_in = ~s;
        check({tag, "_hold"}, state_out, prev);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 12);
        check({tag, "_lat"}, 128'(n), 128'd4);
        check({tag, "_res"}, state_out, exp);
        tick();
        check({tag, "_pulse"}, 128'(done), 128'd0);
    endtask

    initial begin
        logic [127:0] v [3];
        logic [127:0] e [3];
        int           dt [$];
        int           k;
        int           cnt;
        logic [127:0] prev;
        logic [127:0] s;

        rst = 1'b1;
        ena = 1'b0;
        state_in = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_out", state_out, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        run_op(FIPS_IN, 128'd0, FIPS_OUT, "fips");
        run_op(FIXED, FIPS_OUT, FIXED, "fixed");
        run_op(128'd0, FIXED, 128'd0, "zero");

        ena = 1'b1;
        state_in = FIPS_IN;
        tick();
        ena = 1'b0;
        state_in = '0;
        check("ign_busy1", 128'(busy), 128'd1);
        tick();
        check("ign_busy2", 128'(busy), 128'd1);
        ena = 1'b1;
        state_in = FIXED;
        tick();
        ena = 1'b0;
        check("ign_busy3", 128'(busy), 128'd1);
        tick();
        check("ign_busy4", 128'(busy), 128'd1);
        check("ign_nodone", 128'(done), 128'd0);
        tick();
        check("ign_done", 128'(done), 128'd1);
        check("ign_idle", 128'(busy), 128'd0);
        check("ign_res", state_out, FIPS_OUT);
        cnt = 0;
        repeat (10) begin
            tick();
            if (done) cnt++;
        end
        check("ign_extra_done", 128'(cnt), 128'd0);

        v[0] = FIPS_IN; e[0] = FIPS_OUT;
        v[1] = FIXED;   e[1] = FIXED;
        v[2] = ROT_IN;  e[2] = ROT_OUT;
        k = 0;
        ena = 1'b1;
        state_in = v[0];
        tick();
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (done && k < 3) begin
                dt.push_back(t);
                check($sformatf("b2b_res%0d", k), state_out, e[k]);
                k++;
                if (k < 3) state_in = v[k];
                else ena = 1'b0;
            end else begin
                state_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
            end
        end
        ena = 1'b0;
        check("b2b_count", 128'(dt.size()), 128'd3);
        for (int j = 0; j < dt.size() && j < 3; j++)
            check($sformatf("b2b_time%0d", j), 128'(dt[j]), 128'(4 + 5*j));

        ena = 1'b1;
        state_in = FIPS_IN;
        tick();
        ena = 1'b0;
        tick();
        #3 rst = 1'b0;
        #1;
        check("mid_rst_out", state_out, 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            tick();
            if (done || busy) cnt++;
        end
        check("mid_rst_quiet", 128'(cnt), 128'd0);
        run_op(FIPS_IN, 128'd0, FIPS_OUT, "post_rst");

        prev = FIPS_OUT;
        for (int i = 0; i < 10000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_op(mix(s), prev, s, "rt");
            prev = s;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inv_mixcolumns_iter.md
Name: inv_mixcolumns_iter

Overview:
- AES InvMixColumns for the decryption datapath; the inverse of the encryption-side MixColumns stage.
- Column-serial: one 32-bit column per clock, using the fixed matrix rows {0e 0b 0d 09} rotated.
- Accepts a 128-bit state on an `ena` pulse and returns the result with a one-cycle `done` pulse.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round controller.

Parameters:
- NB, 4: columns per state. Fixed at 4 for AES; any other value is a synthesis-time error.
- CLR_ON_START, 0: when 1, `state_out` is cleared to 0 when a new operation is accepted. When 0, `state_out` holds the previous result.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ena  input  1  start request, sampled only in IDLE.
- state_in  input  128  input state.
- state_out  output  128  result, registered; valid when `done`=1 and held until the next result (or the start clear).
- done  output  1  single-cycle completion pulse.
- busy  output  1  high while the operation is in progress.

Behaviour:
- Byte layout: byte k = bits [8k+7:8k]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r. This matches the encryption MixColumns layout.
- Column math, with in0..in3 = rows 0..3 and products in GF(2^8) mod 0x11B:
  - out0 = 0e·in0 ^ 0b·in1 ^ 0d·in2 ^ 09·in3
  - out1 = 09·in0 ^ 0e·in1 ^ 0b·in2 ^ 0d·in3
  - out2 = 0d·in0 ^ 09·in1 ^ 0e·in2 ^ 0b·in3
  - out3 = 0b·in0 ^ 0d·in1 ^ 09·in2 ^ 0e·in3
  - Products are built from chained xtime: x2, x4, x8. Then 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2.
- Reset (rst=0, asynchronous): fsm=IDLE, col=0, work=0, result=0, state_out=0, done=0, busy=0.
- States:
  - IDLE:
    - ena=1 → capture `state_in` into `work`, col=0, busy=1, go to RUN.
    - If CLR_ON_START=1, `state_out` is cleared on the same edge.
    - ena=0 → stay in IDLE.
  - RUN:
    - Each edge writes column `col` of `result` from column `col` of `work`, then col=col+1.
    - On the edge that writes column 3: `state_out` <= full result (column 3 taken directly from the column unit), done=1, busy=0, col=0, go to IDLE.
- Latency: `ena` sampled at edge E → `done` high for exactly the cycle after edge E+4. Throughput is one state per 5 cycles.
- Boundary and ordering rules:
  - `ena` asserted while busy is ignored; no queueing.
  - `ena` asserted during the `done` cycle is accepted: fsm is already IDLE, so the next start is taken at edge E+5.
  - Changes on `state_in` after the capture edge do not affect the result.
  - `done` is a pulse; it is never high for two consecutive cycles in serial mode.
  - Reset asserted mid-RUN aborts immediately to the reset values. No `done` is produced for the aborted operation.
  - `col` is 2 bits and only wraps via the explicit clear on the column-3 edge.

Optional Feature:
- INV_MIXCOLUMNS_UNROLL_EN defined:
  - Four column units are instantiated, and the RUN state is removed.
  - `ena` in IDLE → on the same edge, `state_out` <= InvMixColumns(`state_in`) and done=1.
  - `busy` is tied to 0, and `ena` is accepted every cycle; `done` follows `ena` with a one-cycle delay.
  - CLR_ON_START has no effect.
- Not defined: the single-column-unit serial behaviour above.

Decomposition:
- Shared package `aes_pkg`:
  - GF reduction constant 8'h1B
  - inverse-matrix coefficient constants 8'h0E, 8'h0B, 8'h0D, 8'h09
  - FSM state encoding (IDLE=1'b0, RUN=1'b1)
  - a 32-bit column typedef
- Sub-module `inv_mixcolumn`: combinational, 32-bit column in → 32-bit column out. It reuses the existing `xtime` module three times per byte.

Test Plan:
- FIPS-197 column vectors, all four columns loaded: state_in col0..3 = 0xbca14d8e, 0x9d58dc9f, 0xd6d7d5d5, 0xf8bd7e4d → `done` at E+5, state_out col0..3 = 0x455313db, 0x5c220af2, 0xd5d4d4d4, 0x4c31262d.
- Fixed points: state_in = 128'h01010101_01010101_c6c6c6c6_c6c6c6c6 → state_out identical to the input; state_in = 0 → state_out = 0.
- Round trip: random states passed through encryption MixColumns then this block → original state returned, checked on 10k random states.
- Busy ignore: second `ena` pulsed at E+2 with different data → one `done` only; result belongs to the first state; `busy` is 1 during cycles E+1..E+4.
- Back-to-back: `ena` held high continuously → `done` pulses at E+5, E+10, E+15; each result matches the state captured at its start edge.
- Reset mid-op: rst low at E+2 → `state_out`, `done` and `busy` are 0 asynchronously; no `done` after release; a new `ena` completes normally.
